key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream conditioning stage for the push-button PIO.
- Takes raw, asynchronous, bouncing KEY pins and synchronises each one into clk.
- Debounces each key with a per-key stability counter.
- Drives clean levels into the PIO's in_port, plus one-cycle press/release event pulses for other consumers (game FSM, IRQ logic).

Parameters:
- NUM_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz). Must be >= 2; elaboration error otherwise.
- IDLE_LEVEL, 1'b1: raw pin level when the key is released (board keys are active-low).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- key_raw  in  NUM_KEYS  raw key pins, asynchronous to clk, bouncing.
- key_out  out  NUM_KEYS  debounced level, same polarity as key_raw; connects directly to the PIO in_port.
- key_press  out  NUM_KEYS  1-cycle pulse when the debounced level leaves IDLE_LEVEL.
- key_release  out  NUM_KEYS  1-cycle pulse when the debounced level returns to IDLE_LEVEL.

Behaviour:
- Reset (async assert, sync release via clk):
  - Both synchroniser flops = IDLE_LEVEL.
  - key_out = {NUM_KEYS{IDLE_LEVEL}}.
  - key_press = 0, key_release = 0, all counters = 0, all channels in STABLE.
- Synchroniser: 2-flop chain per key. sync = key_raw delayed 2 clk edges. No logic sits between the flops.
- Per-channel FSM with two states:
  - STABLE: sync == key_out and cnt == 0.
    - When sync != key_out, go to CHANGING with cnt <= 1.
  - CHANGING:
    - If sync == key_out (a bounce back), return to STABLE with cnt <= 0. No output change.
    - Else if cnt == DEBOUNCE_CYCLES-1: key_out <= sync, pulse register set, cnt <= 0, go to STABLE.
    - Else cnt <= cnt + 1.
- Counter width is clog2(DEBOUNCE_CYCLES). The counter never wraps, because it is cleared on acceptance or bounce.
- Latency: after sync first differs and holds, key_out changes on the DEBOUNCE_CYCLES-th subsequent edge. Pin to key_out is DEBOUNCE_CYCLES + 2 edges.
- A glitch shorter than DEBOUNCE_CYCLES cycles (measured at sync) never reaches key_out.
- key_press and key_release are registered:
  - They are high in exactly the cycle key_out first shows the new value, and low otherwise.
  - A press and a release on the same key can never occur in the same cycle.
- Channels are fully independent. Simultaneous transitions on several keys produce simultaneous pulses on the corresponding bits.
- Reset mid-count: the counter is discarded and key_out returns to idle. The press in progress is lost, and no release pulse is generated.
- A key held through reset release is treated as a new press. It produces key_press DEBOUNCE_CYCLES+2 cycles after reset deassertion.

Decomposition:
- Package key_debounce_pkg holds:
  - the state enum {STABLE, CHANGING};
  - a clog2-based width helper for the counter;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, key_debounce_channel, contains a single-key synchroniser, counter, FSM and pulse registers.
- The top instantiates it NUM_KEYS times in a generate loop and concatenates the outputs.

Test Plan (DEBOUNCE_CYCLES=8, NUM_KEYS=2, IDLE_LEVEL=1):
- Reset check: assert reset_n=0 mid-simulation with key_raw=2'b00 -> key_out=2'b11 and pulses=0 immediately (async). After release, key_press=2'b11 pulses exactly 10 edges later.
- Clean press: key_raw[0] 1->0 and held -> key_out[0]=0 on edge 10 after the pin change, key_press[0]=1 for exactly that cycle, key_out[1] unchanged at 1.
- Bounce rejection: key_raw[1] toggles 0,1,0,1 with 3-cycle periods, then holds 0 -> no key_out change during the bounce. key_out[1]=0 8 edges after sync settles, with a single key_press pulse.
- Glitch filter: 7-cycle low pulse on key_raw[0] -> key_out[0] stays 1, and no pulse on any output.
- Release and simultaneity: both keys pressed, then released in the same cycle -> key_release=2'b11 in one cycle, key_out=2'b11, no key_press asserted.
- Mid-count reset: key_raw[0]=0 held for 5 cycles, then reset_n pulsed low -> key_out[0]=1 and cnt cleared. With the key still held, key_press[0] appears 10 edges after release, not earlier.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debounce stage.
package key_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } deb_state_e;

    // 10 ms of stability at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // The counter only has to reach DEBOUNCE_CYCLES-1 before it is cleared.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, stability counter, debounce FSM and event pulses.
//   state    | meaning
//   STABLE   | synchronised pin matches key_out, counter idle at 0
//   CHANGING | pin differs from key_out, counting consecutive stable cycles
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Plain flop-to-flop chain so the first stage has a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            out_q     <= IDLE_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync2_q != out_q) begin
                    state_d = CHANGING;
                    cnt_d   = CW'(1);
                end
            end
            CHANGING: begin
                if (sync2_q == out_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Pulses are registered alongside key_out so they align with the new level.
                    out_d     = sync2_q;
                    press_d   = (sync2_q != IDLE_LEVEL);
                    release_d = (sync2_q == IDLE_LEVEL);
                    cnt_d     = '0;
                    state_d   = STABLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_out     = out_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning ahead of the PIO: independent synchronise+debounce per key,
// clean levels for in_port plus press/release pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   NUM_KEYS        = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_out     (key_out[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with an event scoreboard checked every cycle.
module tb_key_debounce;

    localparam logic [1:0] IDLE = 2'b11;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key_raw = 2'b11;
    logic [1:0] key_out;
    logic [1:0] key_press;
    logic [1:0] key_release;

    typedef struct {
        int         at;
        logic [1:0] out;
        logic [1:0] press;
        logic [1:0] rel;
        string      tag;
    } ev_t;

    ev_t        sb[$];
    int         cyc     = 0;
    int         n_chk   = 0;
    int         n_fail  = 0;
    logic [1:0] exp_out = IDLE;

    key_debounce #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (8),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    // Push an expected event dly rising edges after the stimulus just driven.
    task automatic expect_at(input int dly, input logic [1:0] o, input logic [1:0] p,
                             input logic [1:0] r, input string tag);
        ev_t e;
        e.at = cyc + dly; e.out = o; e.press = p; e.rel = r; e.tag = tag;
        sb.push_back(e);
    endtask

    // Every cycle: either the scheduled event fires now, or pulses must be quiet.
    task automatic check_cycle();
        ev_t e;
        if (!reset_n) exp_out = IDLE;
        if (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            exp_out = e.out;
            chk({e.tag, "_press"}, key_press, e.press);
            chk({e.tag, "_release"}, key_release, e.rel);
        end else begin
            chk("no_press_pulse", key_press, 2'b00);
            chk("no_release_pulse", key_release, 2'b00);
        end
        chk("key_out_level", key_out, exp_out);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        // power-on reset with keys released
        reset_n = 1'b0;
        key_raw = 2'b11;
        tick(3);
        reset_n = 1'b1;
        tick(12);

        // clean press on key 0
        key_raw = 2'b10;
        expect_at(10, 2'b10, 2'b01, 2'b00, "clean_press");
        tick(14);

        // bouncing key 1, 3-cycle segments, then held low
        for (int i = 0; i < 4; i++) begin
            key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        key_raw[1] = 1'b0;
        expect_at(10, 2'b00, 2'b10, 2'b00, "bounce_press");
        tick(14);

        // both released in the same cycle
        key_raw = 2'b11;
        expect_at(10, 2'b11, 2'b00, 2'b11, "release_both");
        tick(14);

        // 7-cycle glitch is filtered
        key_raw[0] = 1'b0;
        tick(7);
        key_raw[0] = 1'b1;
        tick(14);

        // 8-cycle pulse is the shortest accepted
        key_raw[0] = 1'b0;
        expect_at(10, 2'b10, 2'b01, 2'b00, "min_press");
        tick(8);
        key_raw[0] = 1'b1;
        expect_at(10, 2'b11, 2'b00, 2'b01, "min_release");
        tick(14);

        // both pressed together, then reset while held
        key_raw = 2'b00;
        expect_at(10, 2'b00, 2'b11, 2'b00, "press_both");
        tick(12);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out", key_out, IDLE);
        chk("async_rst_press", key_press, 2'b00);
        chk("async_rst_release", key_release, 2'b00);
        tick(3);
        reset_n = 1'b1;
        expect_at(10, 2'b00, 2'b11, 2'b00, "rst_held_press");
        tick(14);

        // release, then reset part way through a count on key 0
        key_raw = 2'b11;
        expect_at(10, 2'b11, 2'b00, 2'b11, "release_both_2");
        tick(14);
        key_raw[0] = 1'b0;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        chk("midcount_rst_out", key_out, IDLE);
        tick(2);
        reset_n = 1'b1;
        expect_at(10, 2'b10, 2'b01, 2'b00, "midcount_press");
        tick(14);

        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drained: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
